// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scan-code prefix bytes (E0 / F0)
//   ps2_state_e                     : frame FSM states
//   ps2_evt_t                       : decoded key event {code, ext, brk}
//   ps2_parity_ok()                 : odd-parity check over data + parity bit
package ps2_pkg;

  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  // Frame parity is odd: data bits plus parity bit must hold an odd count of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one raw PS/2 pin into the clk domain and removes glitches.
//   clk, rst_n : system clock, async active-low reset
//   din        : raw asynchronous pin
//   dout       : filtered level; changes only after FILTER_LEN consecutive
//                equal synchronized samples; resets high (idle bus level)
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Two-stage synchronizer followed by a run-length filter on the synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      dout   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        dout  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: filters kclk/kdata, frames bytes on kclk falling
// edges, folds E0/F0 prefixes into key events and queues them in a FIFO.
//   clk, rst_n           : system clock, async active-low reset
//   kclk, kdata          : raw PS/2 pins
//   evt_valid/evt_ready  : head-of-FIFO handshake
//   evt_code/ext/break   : head event fields (0 when evt_valid=0)
//   err_parity/err_frame : one-cycle error pulses
//   overflow             : one-cycle pulse when an event is dropped on a full FIFO
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic kclk_f;
  logic kdata_f;
  logic kclk_prev_q;
  logic kclk_fall;

  ps2_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [TW-1:0] tmo_cnt_q;
  logic        ext_q;
  logic        brk_q;
  logic        push_q;
  ps2_evt_t    push_evt_q;

  ps2_evt_t    mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  ps2_evt_t    head;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (kclk),
    .dout (kclk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (kdata),
    .dout (kdata_f)
  );

  // Falling edge of the filtered keyboard clock samples kdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kclk_prev_q <= 1'b1;
    else        kclk_prev_q <= kclk_f;
  end

  assign kclk_fall = kclk_prev_q & ~kclk_f;

  // Frame FSM, stall timeout and prefix decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;

      // A stalled frame wins over a coincident strobe: the frame is already dead.
      if ((state_q != ST_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES))) begin
        state_q   <= ST_IDLE;
        tmo_cnt_q <= '0;
        err_frame <= 1'b1;
        ext_q     <= 1'b0;
        brk_q     <= 1'b0;
      end else begin
        if ((state_q == ST_IDLE) || kclk_fall) tmo_cnt_q <= '0;
        else                                   tmo_cnt_q <= tmo_cnt_q + TW'(1);

        if (kclk_fall) begin
          case (state_q)
            ST_IDLE: begin
              if (!kdata_f) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              shift_q   <= {kdata_f, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_q <= ST_PARITY;
            end
            ST_PARITY: begin
              parity_q <= kdata_f;
              state_q  <= ST_STOP;
            end
            ST_STOP: begin
              state_q <= ST_IDLE;
              if (!kdata_f) begin
                err_frame <= 1'b1;
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
              end else if (!ps2_parity_ok(shift_q, parity_q)) begin
                err_parity <= 1'b1;
                ext_q      <= 1'b0;
                brk_q      <= 1'b0;
              end else if (shift_q == PS2_PREFIX_EXT) begin
                ext_q <= 1'b1;
              end else if (shift_q == PS2_PREFIX_BRK) begin
                brk_q <= 1'b1;
              end else begin
                push_q          <= 1'b1;
                push_evt_q.code <= shift_q;
                push_evt_q.ext  <= ext_q;
                push_evt_q.brk  <= brk_q;
                ext_q           <= 1'b0;
                brk_q           <= 1'b0;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Event FIFO: extra pointer bit distinguishes full from empty.
  assign evt_valid = (wptr_q != rptr_q);
  assign fifo_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = push_q && (!fifo_full || pop);
  assign overflow  = push_q && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)     rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Payload storage needs no reset; it is only visible behind evt_valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_evt_q;
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_ext   = evt_valid & head.ext;
  assign evt_break = evt_valid & head.brk;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Scoreboard bench for ps2_rx_decoder: a key-event model predicts events and
// error/overflow pulse counts; a monitor compares every popped event.
module tb_ps2_rx_decoder;

  localparam int unsigned FILTER_LEN     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned HALF           = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  ps2_rx_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kclk      (kclk),
    .kdata     (kdata),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int act_perr = 0, act_ferr = 0, act_ovf = 0;
  bit m_ext = 1'b0, m_brk = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Key-event model: prefixes latch flags, errors clear them, a full queue drops.
  task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    if (bad_stop) begin
      exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (bad_par) begin
      exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({code, m_ext, m_brk});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    kdata = b;
    repeat (HALF) @(posedge clk);
    #1 kclk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    model_frame(code, bad_par, bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(!bad_stop);
    kdata = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
    repeat (5) @(posedge clk);
  endtask

  task automatic check_counts(input string name);
    chk(act_perr == exp_perr, {name, "_err_parity_count"}, act_perr, exp_perr);
    chk(act_ferr == exp_ferr, {name, "_err_frame_count"}, act_ferr, exp_ferr);
    chk(act_ovf == exp_ovf, {name, "_overflow_count"}, act_ovf, exp_ovf);
  endtask

  // Monitor: counts pulse cycles and checks each popped event against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity) act_perr++;
      if (err_frame)  act_ferr++;
      if (overflow)   act_ovf++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_event", {evt_code, evt_ext, evt_break}, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk({evt_code, evt_ext, evt_break} == mon_exp, "event",
              {evt_code, evt_ext, evt_break}, mon_exp);
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) evt_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] code;
    int kind;

    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk({evt_valid, evt_code, evt_ext, evt_break, err_parity, err_frame, overflow} == 14'd0,
        "reset_outputs", {evt_valid, evt_code, evt_ext, evt_break, err_parity, err_frame, overflow}, 0);

    // Basic frame and prefix combinations.
    evt_ready = 1'b1;
    send_frame(8'h1C, 0, 0);
    drain("basic_1c");
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    drain("prefixes");
    check_counts("prefixes");

    // Parity error clears a pending E0; bad stop with bad parity reports frame only.
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 1, 1);
    send_frame(8'h29, 0, 0);
    drain("errors");
    check_counts("errors");

    // Stalled frame after E0: timeout aborts and clears the prefix.
    send_frame(8'hE0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    kdata = 1'b1;
    repeat (TIMEOUT_CYCLES + 300) @(posedge clk);
    exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    check_counts("timeout");
    send_frame(8'h1C, 0, 0);
    drain("after_timeout");
    check_counts("after_timeout");

    // Overflow: fifth event dropped, first four returned in order.
    evt_ready = 1'b0;
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    send_frame(8'h33, 0, 0);
    send_frame(8'h44, 0, 0);
    send_frame(8'h55, 0, 0);
    check_counts("overflow");
    @(negedge clk);
    chk(evt_valid == 1'b1, "full_valid", evt_valid, 1);
    evt_ready = 1'b1;
    drain("overflow_drain");
    @(negedge clk);
    chk(evt_valid == 1'b0, "empty_after_drain", evt_valid, 0);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      code = 8'($urandom_range(0, 255));
      case (kind)
        0: send_frame(code, 1, 0);
        1: send_frame(code, $urandom_range(0, 1) != 0, 1);
        2: send_frame(8'hE0, 0, 0);
        3: send_frame(8'hF0, 0, 0);
        default: send_frame(code, 0, 0);
      endcase
    end
    rand_rdy = 1'b0;
    #2 evt_ready = 1'b1;
    drain("random");
    check_counts("random");

    // Async reset mid-DATA with an event pending.
    evt_ready = 1'b0;
    send_frame(8'h1C, 0, 0);
    @(negedge clk);
    chk(evt_valid == 1'b1, "pending_before_reset", evt_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk({evt_valid, evt_code, evt_ext, evt_break, err_parity, err_frame, overflow} == 14'd0,
        "outputs_in_reset", {evt_valid, evt_code, evt_ext, evt_break, err_parity, err_frame, overflow}, 0);
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0;
    kdata = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h2B, 0, 0);
    drain("after_reset");
    check_counts("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
# ps2_rx_decoder

Fully synchronous PS/2 keyboard receiver that samples the keyboard clock/data lines in the system clock domain. It checks start, parity and stop bits, recovers from stalled frames, and decodes E0/F0 scan-code prefixes into single key events. Events are buffered in a small FIFO behind a valid/ready handshake. It sits between the board PS/2 pins and the game-logic key handler, and replaces the edge-clocked receiver.

## Interface
Parameters:
- FILTER_LEN, 19, consecutive equal samples required before a filtered line changes (≥2).
- TIMEOUT_CYCLES, 100000, idle-clock limit inside a frame before abort (≈1 ms at 100 MHz).
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- kclk  in  1  raw PS/2 clock pin (asynchronous).
- kdata  in  1  raw PS/2 data pin (asynchronous).
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_code  out  8  scan code of the head event.
- evt_ext  out  1  head event was preceded by E0.
- evt_break  out  1  head event was preceded by F0 (key release).
- err_parity  out  1  one-cycle pulse: frame had bad parity.
- err_frame  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: event dropped because the FIFO was full.

## Operation
- Each pin passes through a 2-FF synchronizer and then a filter. The filter output takes the input value after FILTER_LEN consecutive equal samples and resets high.
- A kclk falling edge (filtered prev=1, now=0) is the sample strobe for filtered kdata.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with kdata=0 (start bit), go to DATA with bit count 0. A strobe with kdata=1 is ignored.
  - DATA: shift in 8 bits, LSB first. After bit 7, go to PARITY.
  - PARITY: capture the bit; parity is odd over the 8 data bits plus the parity bit. Go to STOP.
  - STOP: kdata=1 with good parity → byte done. kdata=1 with bad parity → err_parity. kdata=0 → err_frame (this takes precedence over a parity error). Always return to IDLE.
- Timeout: in any state except IDLE, a counter counts cycles since the last strobe. On reaching TIMEOUT_CYCLES it forces IDLE, pulses err_frame and clears the prefix flags. The counter resets on every strobe.
- Prefix decode on byte done:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Any other byte pushes {code, ext, brk} to the FIFO, then clears both flags.
  - Repeated prefixes are idempotent (E0 E0 F0 behaves like E0 F0).
- Any err_parity or err_frame clears the ext and brk flags.
- FIFO:
  - A push when full drops the event and pulses overflow; FIFO contents are unchanged.
  - A simultaneous push and pop when full is accepted, with no overflow.
  - A pop occurs when evt_valid && evt_ready.
  - evt_code/evt_ext/evt_break are undefined-but-stable when evt_valid=0 and are driven to 0 here.
- Reset (asynchronous, at any time, including mid-frame) clears:
  - FSM to IDLE, bit counter, shift register, timeout counter, prefix flags.
  - FIFO to empty.
  - Filters to 1.
  - All outputs to 0.
- The first frame after reset release is received normally if its start edge follows the release.

## Timing
- Pin to filtered change: 2 + FILTER_LEN cycles.
- Strobe cycle N, with stop bit accepted: the decode/push register is written at N+1, and evt_valid=1 at N+2.
- Error pulses are high exactly in cycle N+1 (timeout: the cycle after the counter hits the limit).
- overflow is high in the cycle the push would have occurred (N+1).
- Handshake: the head changes on the cycle after a pop. evt_valid falls the cycle after the last entry is popped. The consumer may hold evt_ready high continuously for back-to-back pops.
- Throughput is bounded by the PS/2 frame time (~1 ms), so the FIFO never needs simultaneous multi-push.

## Structure
- Package ps2_pkg:
  - PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0.
  - Frame FSM state enum.
  - Event struct {code[7:0], ext, brk}.
- Sub-module ps2_line_filter (synchronizer + FILTER_LEN filter, reset value 1), instantiated once for kclk and once for kdata.
- The FIFO is inline: registered array, read/write pointers with one extra wrap bit for full/empty.

## Test plan
- Frame 1C with good parity, evt_ready=1 → one event {1C, ext=0, brk=0}, no error pulses.
- Frames F0, 1C → one event {1C, 0, 1}. Frames E0, F0, 75 → one event {75, 1, 1}.
- E0, then 1C with flipped parity, then 1C → err_parity once, then event {1C, 0, 0} (ext flag cleared).
- Stop kclk after 4 data bits for TIMEOUT_CYCLES → err_frame once, FSM in IDLE, next full 1C frame → {1C, 0, 0}.
- evt_ready=0, send codes 11, 22, 33, 44, 55 → overflow pulses once on 55, then pops return 11, 22, 33, 44 in order.
- Assert rst_n low mid-DATA → all outputs 0 immediately. Release and send 2B → event {2B, 0, 0}.
